// File: rtl/freq_meter_if.sv
// freq_meter_if: enable/input and published-measurement signals of the frequency meter
interface freq_meter_if #(
  parameter int CNT_W = 32
);
  logic             en;
  logic             sig_in;
  logic [CNT_W-1:0] freq;
  logic             freq_valid;
  logic             overflow;
  logic             busy;
  modport master (output en, sig_in, input freq, freq_valid, overflow, busy);
  modport slave  (input en, sig_in, output freq, freq_valid, overflow, busy);
endinterface

// File: rtl/freq_meter.sv
// freq_meter: gated edge counter measuring an asynchronous input over a GATE_MS window
module freq_meter #(
  parameter int CLK_FREQ = 100000000,
  parameter int GATE_MS  = 1000,
  parameter int CNT_W    = 32
) (
  input logic         clkin,
  input logic         rst,
  freq_meter_if.slave bus
);
  localparam int PRE_N = CLK_FREQ / 1000;
  localparam int PRE_W = PRE_N > 1 ? $clog2(PRE_N) : 1;
  localparam int MS_W  = GATE_MS > 1 ? $clog2(GATE_MS) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRE_N - 1);
  localparam logic [MS_W-1:0]  MS_MAX  = MS_W'(GATE_MS - 1);
  typedef enum logic {IDLE, COUNT} state_e;
  state_e           state_q;
  logic             sync1_q, sync2_q, prev_q;
  logic [PRE_W-1:0] pre_q;
  logic [MS_W-1:0]  ms_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, freq_q;
  logic             sat_q, sat_d, valid_q, ovf_q;
  logic             rise, ms_tick, last, cnt_full;
  assign rise     = sync2_q & ~prev_q;
  assign ms_tick  = pre_q == PRE_MAX;
  assign last     = (state_q == COUNT) && ms_tick && (ms_q == MS_MAX);
  assign cnt_full = &cnt_q;
  // the closing cycle's edge is folded in here so it lands in the published result
  assign cnt_d    = (rise && !cnt_full) ? cnt_q + CNT_W'(1) : cnt_q;
  assign sat_d    = sat_q | (rise & cnt_full);
  always_ff @(posedge clkin) begin
    if (rst) begin
      state_q <= IDLE;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pre_q   <= '0;
      ms_q    <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      freq_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sync1_q <= bus.sig_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      valid_q <= last;
      state_q <= bus.en ? COUNT : IDLE;
      if (last) begin
        freq_q <= cnt_d;
        ovf_q  <= sat_d;
      end
      // counters run only mid-window; idle, abort and window end all restart them at 0
      if (state_q == COUNT && bus.en && !last) begin
        pre_q <= ms_tick ? '0 : pre_q + PRE_W'(1);
        ms_q  <= ms_tick ? ms_q + MS_W'(1) : ms_q;
        cnt_q <= cnt_d;
        sat_q <= sat_d;
      end else begin
        pre_q <= '0;
        ms_q  <= '0;
        cnt_q <= '0;
        sat_q <= 1'b0;
      end
    end
  end
  assign bus.freq       = freq_q;
  assign bus.freq_valid = valid_q;
  assign bus.overflow   = ovf_q;
  assign bus.busy       = state_q == COUNT;
endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: directed checks of a 32-bit and a 3-bit meter with a 20-cycle window
module tb_freq_meter;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, sig = 1'b0, lvl = 1'b0;
  int per = 2, ph = 0, n_chk = 0, n_err = 0, n_v;
  always #5 clk = ~clk;
  freq_meter_if #(.CNT_W(32)) if_w ();
  freq_meter_if #(.CNT_W(3))  if_n ();
  assign if_w.en = en;
  assign if_w.sig_in = sig;
  assign if_n.en = en;
  assign if_n.sig_in = sig;
  freq_meter #(.CLK_FREQ(10000), .GATE_MS(2), .CNT_W(32)) u_w (.clkin(clk), .rst(rst), .bus(if_w));
  freq_meter #(.CLK_FREQ(10000), .GATE_MS(2), .CNT_W(3))  u_n (.clkin(clk), .rst(rst), .bus(if_n));
  // input pattern: per=0 holds lvl, else high for per/2 cycles then low
  initial forever begin
    @(negedge clk);
    if (per == 0) sig = lvl;
    else begin
      sig = ph < per / 2;
      ph = (ph + 1) % per;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic wait_pub(input string tag, input int lim, input int exp);
    int cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!if_w.freq_valid && cyc < lim);
    chk(tag, cyc, exp);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_w"}, if_w.freq, 0);
    chk({tag, "_flags"}, {if_n.freq, if_w.freq_valid, if_w.overflow, if_w.busy,
        if_n.freq_valid, if_n.overflow, if_n.busy}, 0);
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_zero("reset");
    end
    rst = 1'b0;
    per = 4;
    repeat (5) tick();
    en = 1'b1;
    tick();
    chk("busy_rise", if_w.busy, 1);
    wait_pub("first_pub", 30, 20);
    tick();
    chk("valid_pulse", if_w.freq_valid, 0);
    wait_pub("period", 30, 19);
    chk("sq_freq", if_w.freq, 5);
    chk("sq_ovf", if_w.overflow, 0);
    chk("sq_valid_n", if_n.freq_valid, 1);
    wait_pub("period2", 30, 20);
    chk("sq_freq2", if_n.freq, 5);
    per = 0;
    lvl = 1'b1;
    wait_pub("hi_trans", 30, 20);
    wait_pub("hi_pub", 30, 20);
    chk("hi_freq", if_w.freq, 0);
    lvl = 1'b0;
    wait_pub("lo_trans", 30, 20);
    wait_pub("lo_pub", 30, 20);
    chk("lo_freq", if_w.freq, 0);
    per = 2;
    ph = 0;
    wait_pub("sat_pub1", 30, 20);
    chk("sat1_w", if_w.freq, 9);
    chk("sat1_n", if_n.freq, 7);
    chk("sat1_ovf_n", if_n.overflow, 1);
    wait_pub("sat_pub2", 30, 20);
    chk("sat2_w", if_w.freq, 10);
    chk("sat2_ovf_w", if_w.overflow, 0);
    chk("sat2_n", if_n.freq, 7);
    chk("sat2_ovf_n", if_n.overflow, 1);
    per = 10;
    ph = 0;
    wait_pub("p10_trans", 30, 20);
    wait_pub("p10_pub", 30, 20);
    chk("p10_n", if_n.freq, 2);
    chk("p10_ovf_n", if_n.overflow, 0);
    chk("p10_w", if_w.freq, 2);
    per = 4;
    ph = 0;
    wait_pub("p4_trans", 30, 20);
    wait_pub("p4_pub", 30, 20);
    chk("p4_freq", if_w.freq, 5);
    repeat (10) tick();
    en = 1'b0;
    tick();
    chk("abort_busy", if_w.busy, 0);
    n_v = 0;
    for (int i = 0; i < 25; i++) begin
      n_v += int'(if_w.freq_valid) + int'(if_n.freq_valid);
      tick();
    end
    chk("abort_novalid", n_v, 0);
    chk("abort_freq", if_w.freq, 5);
    en = 1'b1;
    wait_pub("reen_lat", 30, 21);
    chk("reen_freq", if_w.freq, 5);
    repeat (19) tick();
    en = 1'b0;
    tick();
    chk("lastcyc_valid", if_w.freq_valid, 1);
    chk("lastcyc_busy", if_w.busy, 0);
    tick();
    chk("lastcyc_pulse", if_w.freq_valid, 0);
    chk("lastcyc_freq", if_w.freq, 5);
    en = 1'b1;
    wait_pub("pre_rst_lat", 30, 21);
    repeat (12) tick();
    rst = 1'b1;
    tick();
    chk_zero("mid_rst");
    rst = 1'b0;
    ph = 0;
    wait_pub("post_rst_lat", 30, 21);
    chk("post_rst_w", if_w.freq, 5);
    chk("post_rst_n", if_n.freq, 5);
    chk("post_rst_ovf", if_n.overflow, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
